// File: rtl/alu_exec_if.sv
// Handshake and operand bus between the ID/EX stage and the execute-stage ALU.
// The issuer drives the master side and the ALU sits on the slave side.
interface alu_exec_if #(
   parameter int XLEN = 32
);
   logic            flush_i;
   logic            valid_i;
   logic            ready_o;
   logic [1:0]      ALUOp_i;
   logic [9:0]      funct_i;
   logic [XLEN-1:0] data1_i;
   logic [XLEN-1:0] data2_i;
   logic            valid_o;
   logic [XLEN-1:0] data_o;
   logic            zero_o;

   modport master (
      output flush_i, valid_i, ALUOp_i, funct_i, data1_i, data2_i,
      input  ready_o, valid_o, data_o, zero_o
   );

   modport slave (
      input  flush_i, valid_i, ALUOp_i, funct_i, data1_i, data2_i,
      output ready_o, valid_o, data_o, zero_o
   );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: decodes ALUOp/funct, registers single-cycle results and runs
// MUL as an iterative shift-and-add that holds ready low until the product is done.
module alu_exec_unit #(
   parameter int XLEN     = 32,
   parameter int MUL_BITS = 1
) (
   input  logic     clk_i,
   input  logic     rst_i,
   alu_exec_if.slave bus
);
   localparam int STEPS = XLEN / MUL_BITS;
   localparam int SHW   = $clog2(XLEN);
   localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

   typedef enum logic {ST_IDLE, ST_MUL} state_t;
   typedef enum logic [3:0] {
      OP_ADD, OP_SUB, OP_MUL, OP_OR, OP_AND, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SLT
   } op_t;

   state_t          state;
   op_t             op;
   logic [XLEN-1:0] alu_res;
   logic [XLEN-1:0] mul_sum;
   logic [XLEN-1:0] acc;
   logic [XLEN-1:0] mcand;
   logic [XLEN-1:0] mplier;
   logic [CNT_W-1:0] cnt;
   logic            valid_q;
   logic [XLEN-1:0] data_q;
   logic            zero_q;
   logic            accept;
   logic [SHW-1:0]  shamt;

   assign bus.ready_o = (state == ST_IDLE) & ~rst_i;
   assign bus.valid_o = valid_q;
   assign bus.data_o  = data_q;
   assign bus.zero_o  = zero_q;
   assign accept      = bus.valid_i & bus.ready_o & ~bus.flush_i;
   assign shamt       = bus.data2_i[SHW-1:0];

   // Unlisted R-type codes and ALUOp 00 both fall back to ADD
   always_comb begin
      op = OP_ADD;
      case (bus.ALUOp_i)
         2'b01: op = OP_SUB;
         2'b10: begin
            case (bus.funct_i)
               10'b0000000_000: op = OP_ADD;
               10'b0100000_000: op = OP_SUB;
               10'b0000001_000: op = OP_MUL;
               10'b0000000_110: op = OP_OR;
               10'b0000000_111: op = OP_AND;
               10'b0000000_100: op = OP_XOR;
               10'b0000000_001: op = OP_SLL;
               10'b0000000_101: op = OP_SRL;
               10'b0100000_101: op = OP_SRA;
               10'b0000000_010: op = OP_SLT;
               default:         op = OP_ADD;
            endcase
         end
         default: op = OP_ADD;
      endcase
   end

   always_comb begin
      alu_res = '0;
      case (op)
         OP_ADD: alu_res = bus.data1_i + bus.data2_i;
         OP_SUB: alu_res = bus.data1_i - bus.data2_i;
         OP_OR:  alu_res = bus.data1_i | bus.data2_i;
         OP_AND: alu_res = bus.data1_i & bus.data2_i;
         OP_XOR: alu_res = bus.data1_i ^ bus.data2_i;
         OP_SLL: alu_res = bus.data1_i << shamt;
         OP_SRL: alu_res = bus.data1_i >> shamt;
         OP_SRA: alu_res = $signed(bus.data1_i) >>> shamt;
         OP_SLT: alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.data1_i) < $signed(bus.data2_i))};
         default: alu_res = '0;
      endcase
   end

   // One radix-2^MUL_BITS step: add a shifted copy of mcand per set multiplier bit
   always_comb begin
      mul_sum = acc;
      for (int j = 0; j < MUL_BITS; j++) begin
         if (mplier[j]) mul_sum = mul_sum + (mcand << j);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= ST_IDLE;
         valid_q <= 1'b0;
         data_q  <= '0;
         zero_q  <= 1'b0;
         acc     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         cnt     <= '0;
      end else begin
         valid_q <= 1'b0;
         if (bus.flush_i) begin
            state <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (accept) begin
                     if (op == OP_MUL) begin
                        acc    <= '0;
                        mcand  <= bus.data1_i;
                        mplier <= bus.data2_i;
                        cnt    <= CNT_W'(STEPS - 1);
                        state  <= ST_MUL;
                     end else begin
                        data_q  <= alu_res;
                        zero_q  <= (alu_res == '0);
                        valid_q <= 1'b1;
                     end
                  end
               end
               ST_MUL: begin
                  acc    <= mul_sum;
                  mcand  <= mcand << MUL_BITS;
                  mplier <= mplier >> MUL_BITS;
                  if (cnt == '0) begin
                     data_q  <= mul_sum;
                     zero_q  <= (mul_sum == '0);
                     valid_q <= 1'b1;
                     state   <= ST_IDLE;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed and random checks of alu_exec_unit against an arithmetic reference model.
module tb_alu_exec_unit;
   logic clk;
   logic rst;
   int   compared;
   int   mismatched;

   alu_exec_if #(.XLEN(32)) bus ();

   alu_exec_unit #(.XLEN(32), .MUL_BITS(1)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] refAlu(input logic [1:0] aluop, input logic [9:0] funct,
                                          input logic [31:0] a, input logic [31:0] b);
      logic [63:0] prod;
      int unsigned sh;
      sh = b % 32;
      if (aluop == 2'b01) return a - b;
      if (aluop != 2'b10) return a + b;
      case (funct)
         10'h100: return a - b;
         10'h008: begin
            prod = {32'd0, a} * {32'd0, b};
            return prod[31:0];
         end
         10'h006: return a | b;
         10'h007: return a & b;
         10'h004: return a ^ b;
         10'h001: return a << sh;
         10'h005: return a >> sh;
         10'h105: return (a >> sh) | (a[31] ? ~(32'hFFFFFFFF >> sh) : 32'd0);
         10'h002: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         default: return a + b;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] aluop, input logic [9:0] funct,
                                input logic [31:0] a, input logic [31:0] b);
      bus.valid_i = 1'b1;
      bus.ALUOp_i = aluop;
      bus.funct_i = funct;
      bus.data1_i = a;
      bus.data2_i = b;
   endtask

   // Issue one op, wait a bounded time for its result and check latency, data and zero
   task automatic runOp(input string tag, input logic [1:0] aluop, input logic [9:0] funct,
                        input logic [31:0] a, input logic [31:0] b);
      logic [31:0] exp;
      int lat;
      bit is_mul;
      exp    = refAlu(aluop, funct, a, b);
      is_mul = (aluop == 2'b10) && (funct == 10'h008);
      applyStimulus(aluop, funct, a, b);
      tick();
      bus.valid_i = 1'b0;
      lat = 1;
      while (!bus.valid_o && lat < 60) begin
         tick();
         lat++;
      end
      checkOutput({tag, "_lat"}, 32'(lat), is_mul ? 32'd33 : 32'd1);
      checkOutput({tag, "_data"}, bus.data_o, exp);
      checkOutput({tag, "_zero"}, {31'd0, bus.zero_o}, {31'd0, exp == 32'd0});
   endtask

   logic [9:0]  codes [10];
   logic [31:0] exp_q [$];
   logic [31:0] held;
   int          pulses;

   initial begin
      compared   = 0;
      mismatched = 0;
      codes = '{10'h000, 10'h100, 10'h008, 10'h006, 10'h007,
                10'h004, 10'h001, 10'h005, 10'h105, 10'h002};
      rst         = 1'b1;
      bus.flush_i = 1'b0;
      bus.valid_i = 1'b0;
      bus.ALUOp_i = 2'b00;
      bus.funct_i = '0;
      bus.data1_i = '0;
      bus.data2_i = '0;
      tick();
      tick();
      checkOutput("rst_valid", {31'd0, bus.valid_o}, 32'd0);
      checkOutput("rst_data", bus.data_o, 32'd0);
      checkOutput("rst_ready", {31'd0, bus.ready_o}, 32'd0);
      rst = 1'b0;
      #1;
      checkOutput("rel_ready", {31'd0, bus.ready_o}, 32'd1);

      $display("[TB] add/sub/zero");
      runOp("add5_7", 2'b11, 10'h000, 32'd5, 32'd7);
      checkOutput("add_data", bus.data_o, 32'd12);
      runOp("sub9_9", 2'b01, 10'h000, 32'd9, 32'd9);
      checkOutput("sub_zero", {31'd0, bus.zero_o}, 32'd1);
      tick();
      checkOutput("pulse_end", {31'd0, bus.valid_o}, 32'd0);
      checkOutput("hold_zero", {31'd0, bus.zero_o}, 32'd1);

      $display("[TB] multi-cycle MUL with ignored issue");
      applyStimulus(2'b10, 10'h008, 32'hFFFFFFFF, 32'd3);
      tick();
      applyStimulus(2'b11, 10'h000, 32'd100, 32'd1);
      for (int k = 1; k <= 32; k++) begin
         if (k == 8) bus.valid_i = 1'b0;
         checkOutput("mul_busy", {30'd0, bus.ready_o, bus.valid_o}, 32'd0);
         tick();
      end
      checkOutput("mul_valid", {30'd0, bus.ready_o, bus.valid_o}, 32'd3);
      checkOutput("mul_data", bus.data_o, 32'hFFFFFFFD);
      tick();
      checkOutput("mul_ignored", {31'd0, bus.valid_o}, 32'd0);
      checkOutput("mul_hold", bus.data_o, 32'hFFFFFFFD);

      $display("[TB] reset mid-MUL");
      applyStimulus(2'b10, 10'h008, 32'd7, 32'd9);
      tick();
      bus.valid_i = 1'b0;
      repeat (4) tick();
      #2;
      rst = 1'b1;
      #1;
      checkOutput("arst_valid", {31'd0, bus.valid_o}, 32'd0);
      checkOutput("arst_data", bus.data_o, 32'd0);
      checkOutput("arst_zero_rdy", {30'd0, bus.zero_o, bus.ready_o}, 32'd0);
      tick();
      rst = 1'b0;
      #1;
      checkOutput("arst_ready", {31'd0, bus.ready_o}, 32'd1);
      pulses = 0;
      repeat (40) begin
         tick();
         if (bus.valid_o) pulses++;
      end
      checkOutput("arst_no_result", 32'(pulses), 32'd0);

      $display("[TB] shifts and SLT");
      runOp("sra", 2'b10, 10'h105, 32'h80000000, 32'd4);
      checkOutput("sra_val", bus.data_o, 32'hF8000000);
      runOp("srl", 2'b10, 10'h005, 32'h80000000, 32'd4);
      checkOutput("srl_val", bus.data_o, 32'h08000000);
      runOp("slt", 2'b10, 10'h002, 32'hFFFFFFFF, 32'd1);
      checkOutput("slt_val", bus.data_o, 32'd1);
      runOp("sub0_1", 2'b01, 10'h000, 32'd0, 32'd1);
      checkOutput("sub_wrap", bus.data_o, 32'hFFFFFFFF);

      $display("[TB] flush");
      held = bus.data_o;
      applyStimulus(2'b10, 10'h008, 32'd12345, 32'd678);
      tick();
      bus.valid_i = 1'b0;
      repeat (9) tick();
      bus.flush_i = 1'b1;
      tick();
      bus.flush_i = 1'b0;
      checkOutput("flush_ready", {30'd0, bus.ready_o, bus.valid_o}, 32'd2);
      checkOutput("flush_hold", bus.data_o, held);
      runOp("after_flush", 2'b11, 10'h000, 32'd1, 32'd1);
      checkOutput("after_flush_val", bus.data_o, 32'd2);
      pulses = 0;
      repeat (40) begin
         tick();
         if (bus.valid_o) pulses++;
      end
      checkOutput("flush_no_result", 32'(pulses), 32'd0);
      applyStimulus(2'b11, 10'h000, 32'd3, 32'd4);
      bus.flush_i = 1'b1;
      tick();
      bus.flush_i = 1'b0;
      bus.valid_i = 1'b0;
      checkOutput("flush_blocks", {31'd0, bus.valid_o}, 32'd0);
      checkOutput("flush_blocks_data", bus.data_o, 32'd2);

      $display("[TB] back-to-back throughput");
      exp_q.delete();
      for (int i = 0; i < 4; i++) begin
         logic [31:0] a;
         logic [31:0] b;
         a = $urandom;
         b = $urandom;
         exp_q.push_back(refAlu(2'b10, codes[i == 0 ? 0 : (i == 1 ? 1 : (i == 2 ? 3 : 4))], a, b));
         applyStimulus(2'b10, codes[i == 0 ? 0 : (i == 1 ? 1 : (i == 2 ? 3 : 4))], a, b);
         tick();
         checkOutput("tput_valid", {31'd0, bus.valid_o}, 32'd1);
         checkOutput("tput_data", bus.data_o, exp_q.pop_front());
      end
      bus.valid_i = 1'b0;
      tick();
      checkOutput("tput_end", {31'd0, bus.valid_o}, 32'd0);

      $display("[TB] random operations");
      for (int n = 0; n < 150; n++) begin
         logic [1:0]  aluop;
         logic [9:0]  funct;
         logic [31:0] a;
         logic [31:0] b;
         aluop = 2'($urandom_range(0, 3));
         funct = ($urandom_range(0, 7) == 0) ? 10'($urandom) : codes[$urandom_range(0, 9)];
         a = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom);
         b = ($urandom_range(0, 5) == 0) ? a : 32'($urandom);
         runOp("rnd", aluop, funct, a, b);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
